mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 26 ++
 rtl/byte_word_sequencer.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//   state_t        : arbiter FSM states
//   BYTES_PER_WORD : bytes moved per word transaction
//   DEFAULT_ADDR_W : default byte-address width
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_ADDR_W = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - byte-wide shared memory bus
//   mem_addr  : byte address
//   mem_re    : read strobe
//   mem_we    : write strobe (never together with mem_re)
//   mem_wdata : write byte
//   mem_rdata : read byte, valid in the same cycle as mem_addr
//   modport master : arbiter side, modport slave : memory side
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/byte_word_sequencer.sv
// rtl/byte_word_sequencer.sv - byte index, address increment, lane assembly and write-lane select
//   clk, rst_n : clock, asynchronous active-low reset
//   capture    : latch base address and write word (asserted with a grant)
//   active     : transfer in progress; idx advances each cycle, else held at 0
//   base_in    : byte address to latch
//   wdata_in   : write word to latch
//   rdata      : byte returned by memory this cycle
//   addr       : base + idx, wrapping modulo 2^ADDR_W
//   wbyte      : write byte for the current lane
//   last       : current byte is the final lane of the word
//   word       : assembled word, complete in the cycle where last is high
module byte_word_sequencer
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BYTES  = BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic              active,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [31:0]       wdata_in,
    input  logic [7:0]        rdata,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wbyte,
    output logic              last,
    output logic [31:0]       word
);
    localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

    logic [1:0]        idx;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q;
    logic [23:0]       asm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 2'd0;
            base    <= '0;
            wdata_q <= 32'd0;
            asm_q   <= 24'd0;
        end else begin
            if (capture) begin
                base    <= base_in;
                wdata_q <= wdata_in;
            end
            if (active) begin
                idx   <= idx + 2'd1;
                // Lower lanes shift in from the top so byte 0 ends up in [7:0]
                asm_q <= {rdata, asm_q[23:8]};
            end else begin
                idx   <= 2'd0;
            end
        end
    end

    assign addr  = base + {{(ADDR_W-2){1'b0}}, idx};
    assign wbyte = wdata_q[{idx, 3'b000} +: 8];
    assign last  = (idx == LAST_IDX);
    // The final byte is taken straight from memory so the word is ready at the last edge
    assign word  = {rdata, asm_q};
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and load/store ports onto one byte-wide memory
//   Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin instead of ls-first priority)
//   clk, rst_n                    : clock, asynchronous active-low reset
//   if_req/if_addr/if_flush       : fetch request, address, redirect abort
//   if_gnt/if_done/if_data        : fetch accepted pulse, done pulse, fetched word
//   ls_req/ls_we/ls_addr/ls_wdata : data request, write flag, address, write word
//   ls_gnt/ls_done/ls_rdata       : data accepted pulse, done pulse, load word
//   busy                          : FSM not idle
//   mem                           : shared memory bus (master side)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BYTES  = BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              busy,
    mem_port_arbiter_if.master mem
);
    state_t            state;
    logic              run_q;
    logic              idle;
    logic              if_ok;
    logic              grant_ls;
    logic              grant_if;
    logic              seq_last;
    logic [31:0]       seq_word;
    logic [7:0]        seq_wbyte;
    logic [ADDR_W-1:0] seq_addr;

    // run_q keeps grants off while reset is asserted without gating
    // combinational logic on the reset net itself
    assign idle  = run_q && (state == ST_IDLE);
    assign if_ok = if_req && !if_flush;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ls;  // 1: ls port was served most recently

    assign grant_ls = idle && ls_req && (!if_ok || !last_ls);
`else
    assign grant_ls = idle && ls_req;
`endif
    assign grant_if = idle && if_ok && !grant_ls;

    assign if_gnt = grant_if;
    assign ls_gnt = grant_ls;
    assign busy   = (state != ST_IDLE);

    byte_word_sequencer #(
        .ADDR_W (ADDR_W),
        .BYTES  (BYTES)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .capture  (grant_ls || grant_if),
        .active   (state != ST_IDLE),
        .base_in  (grant_ls ? ls_addr : if_addr),
        .wdata_in (ls_wdata),
        .rdata    (mem.mem_rdata),
        .addr     (seq_addr),
        .wbyte    (seq_wbyte),
        .last     (seq_last),
        .word     (seq_word)
    );

    assign mem.mem_addr  = seq_addr;
    assign mem.mem_re    = (state == ST_FETCH) || (state == ST_LOAD);
    assign mem.mem_we    = (state == ST_STORE);
    assign mem.mem_wdata = (state == ST_STORE) ? seq_wbyte : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            run_q    <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_data  <= 32'd0;
            ls_rdata <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_ls  <= 1'b0;
`endif
        end else begin
            run_q   <= 1'b1;
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_ls) begin
                        state <= ls_we ? ST_STORE : ST_LOAD;
                    end else if (grant_if) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // A redirect kills the fetch outright; if_data keeps its old word
                    if (if_flush) begin
                        state <= ST_IDLE;
                    end else if (seq_last) begin
                        state   <= ST_IDLE;
                        if_done <= 1'b1;
                        if_data <= seq_word;
                    end
                end
                ST_LOAD: begin
                    if (seq_last) begin
                        state    <= ST_IDLE;
                        ls_done  <= 1'b1;
                        ls_rdata <= seq_word;
                    end
                end
                ST_STORE: begin
                    if (seq_last) begin
                        state   <= ST_IDLE;
                        ls_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef ARB_ROUND_ROBIN_EN
            if (grant_ls) begin
                last_ls <= 1'b1;
            end else if (grant_if) begin
                last_ls <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, if_gnt, if_done;
    logic [31:0] if_addr = 32'd0, if_data;
    logic        ls_req = 1'b0, ls_we = 1'b0, ls_gnt, ls_done;
    logic [31:0] ls_addr = 32'd0, ls_wdata = 32'd0, ls_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_port_arbiter_if #(.ADDR_W(32)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(32), .BYTES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_gnt   (if_gnt),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_gnt   (ls_gnt),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .busy     (busy),
        .mem      (mem_bus)
    );

    // Memory model: 16 bytes aliased on addr[3:0], plus write log and read/strobe monitors
    logic [7:0]  mem_model [16];
    logic [39:0] wr_log [$];
    bit          preloaded = 0;
    int          rd3_cnt = 0;
    int          both_cnt = 0;

    assign mem_bus.mem_rdata = mem_model[mem_bus.mem_addr[3:0]];

    always @(negedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 16; i++) mem_model[i] = (i < 8) ? 8'(8'h11 * (i + 1)) : 8'h00;
            preloaded = 1;
        end
        if (mem_bus.mem_re && mem_bus.mem_we) both_cnt++;
        if (mem_bus.mem_re && mem_bus.mem_addr == 32'd3) rd3_cnt++;
        if (mem_bus.mem_we) begin
            wr_log.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
            mem_model[mem_bus.mem_addr[3:0]] = mem_bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {17'd0, if_gnt, if_done, if_data, ls_gnt, ls_done, ls_rdata, busy,
                mem_bus.mem_addr, mem_bus.mem_re, mem_bus.mem_we, mem_bus.mem_wdata};
    endfunction

    // op: 0 fetch, 1 load, 2 store. Called just after a rising edge.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got, output int lat);
        int g, d;
        g = -1; d = -1; got = 32'd0;
        if (op == 0) begin
            if_addr = a; if_req = 1'b1;
        end else begin
            ls_addr = a; ls_wdata = wd; ls_we = (op == 2); ls_req = 1'b1;
        end
        for (int k = 0; k < 10 && g < 0; k++) begin
            @(negedge clk);
            if ((op == 0) ? if_gnt : ls_gnt) g = cyc;
        end
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        for (int k = 0; k < 10 && d < 0; k++) begin
            @(negedge clk);
            if ((op == 0) ? if_done : ls_done) begin
                d = cyc;
                got = (op == 0) ? if_data : ls_rdata;
            end
        end
        lat = (g < 0 || d < 0) ? -1 : d - g;
        @(posedge clk); #1;
    endtask

    typedef struct {
        string       name;
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] got;
    int          lat;
    int          ig, lg, id, ld, n_ig, n_lg, n0, rd3_snap, cnt_a, cnt_b;
    logic [31:0] idat, ldat;
    logic        first_ls, exp_first_ls;
    logic [39:0] exp_wr [4];

    initial begin
        vecs[0] = '{"fetch_a0", 0, 32'h0000_0000, 32'h0,         32'h4433_2211};
        vecs[1] = '{"load_a4",  1, 32'h0000_0004, 32'h0,         32'h8877_6655};
        vecs[2] = '{"fetch_a2", 0, 32'h0000_0002, 32'h0,         32'h6655_4433};
        vecs[3] = '{"load_a1",  1, 32'h0000_0001, 32'h0,         32'h5544_3322};
        vecs[4] = '{"store_a8", 2, 32'h0000_0008, 32'hA1B2_C3D4, 32'h0};
        vecs[5] = '{"load_a8",  1, 32'h0000_0008, 32'h0,         32'hA1B2_C3D4};
        vecs[6] = '{"fetch_a9", 0, 32'h0000_0009, 32'h0,         32'h00A1_B2C3};

        // Reset state, with requests present
        repeat (2) @(posedge clk);
        #1 if_req = 1'b1; ls_req = 1'b1;
        #1 check("reset_outputs", all_outs(), 128'd0);
        if_req = 1'b0; ls_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, got, lat);
            check({vecs[i].name, "_latency"}, lat, 5);
            if (vecs[i].op != 2) check({vecs[i].name, "_data"}, got, vecs[i].exp);
        end

        // Leave ls as last served, then collide fetch@0 with load@4
        run_op(1, 32'd4, 32'd0, got, lat);
        check("pre_arb_load", got, 32'h8877_6655);
        ig = -1; lg = -1; id = -1; ld = -1; n_ig = 0; n_lg = 0;
        if_addr = 32'd0; ls_addr = 32'd4; ls_we = 1'b0; if_req = 1'b1; ls_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (if_gnt) begin n_ig++; if (ig < 0) ig = cyc; end
            if (ls_gnt) begin n_lg++; if (lg < 0) lg = cyc; end
            if (if_done && id < 0) begin id = cyc; idat = if_data; end
            if (ls_done && ld < 0) begin ld = cyc; ldat = ls_rdata; end
            @(posedge clk); #1;
            if (ig >= 0) if_req = 1'b0;
            if (lg >= 0) ls_req = 1'b0;
        end
        if_req = 1'b0; ls_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_first_ls = 1'b0;
`else
        exp_first_ls = 1'b1;
`endif
        first_ls = (lg >= 0) && (ig < 0 || lg < ig);
        check("arb_first_winner_ls", first_ls, exp_first_ls);
        check("arb_second_gnt_at_done", first_ls ? ig : lg, first_ls ? ld : id);
        check("arb_gnt_counts", {n_ig, n_lg}, {32'd1, 32'd1});
        check("arb_if_data", idat, 32'h4433_2211);
        check("arb_ls_rdata", ldat, 32'h8877_6655);

        // Flush in IDLE suppresses the fetch grant for that cycle only
        if_addr = 32'd0; if_req = 1'b1; if_flush = 1'b1;
        @(negedge clk);
        check("flush_idle_no_gnt", if_gnt, 1'b0);
        @(posedge clk); #1 if_flush = 1'b0;
        @(negedge clk);
        check("flush_idle_then_gnt", if_gnt, 1'b1);
        // That cycle is G; flush the fetch in G+2
        @(posedge clk); #1 if_req = 1'b0; rd3_snap = rd3_cnt;
        @(posedge clk); #1 if_flush = 1'b1;
        @(posedge clk); #1 if_flush = 1'b0;
        @(negedge clk);
        check("flush_fetch_busy_low", busy, 1'b0);
        cnt_a = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if_done) cnt_a++;
        end
        check("flush_fetch_no_done", cnt_a, 0);
        check("flush_fetch_data_kept", if_data, 32'h4433_2211);
        check("flush_fetch_byte3_unread", rd3_cnt, rd3_snap);

        // Flush has no effect on a load
        @(posedge clk); #1 if_flush = 1'b1;
        run_op(1, 32'd0, 32'd0, got, lat);
        if_flush = 1'b0;
        check("flush_load_latency", lat, 5);
        check("flush_load_data", got, 32'h4433_2211);

        // Reset in G+3 of a load
        ls_addr = 32'd4; ls_we = 1'b0; ls_req = 1'b1;
        @(negedge clk);
        check("rst_load_gnt", ls_gnt, 1'b1);
        @(posedge clk); #1 ls_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("rst_mid_outputs", all_outs(), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ls_done) cnt_a++;
            if (ls_gnt) cnt_b++;
        end
        check("rst_no_done", cnt_a, 0);
        check("rst_no_gnt_without_req", cnt_b, 0);
        @(posedge clk); #1;
        run_op(1, 32'd4, 32'd0, got, lat);
        check("rst_rereq_latency", lat, 5);
        check("rst_rereq_data", got, 32'h8877_6655);

        // Store across the top of the address space
        n0 = wr_log.size();
        run_op(2, 32'hFFFF_FFFE, 32'hDEAD_BEEF, got, lat);
        check("wrap_store_latency", lat, 5);
        check("wrap_store_writes", wr_log.size(), n0 + 4);
        exp_wr[0] = {32'hFFFF_FFFE, 8'hEF};
        exp_wr[1] = {32'hFFFF_FFFF, 8'hBE};
        exp_wr[2] = {32'h0000_0000, 8'hAD};
        exp_wr[3] = {32'h0000_0001, 8'hDE};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_store_byte%0d", i),
                  (n0 + i < wr_log.size()) ? wr_log[n0 + i] : 40'd0, exp_wr[i]);
        end

        check("re_we_never_both", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
